// File: rtl/baud_gen_frac.sv
// Fractional phase-accumulator baud tick generator: oversample and bit ticks
// with a run-time rate select whose changes take effect on a bit boundary.
module baud_gen_frac #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned OVERSAMPLE  = 8,
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned DEFAULT_SEL = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [2:0] baud_sel,
    input  logic       sel_load,
    output logic       os_tick,
    output logic       bit_tick,
    output logic [2:0] cur_sel,
    output logic       sel_pend
);

    localparam int unsigned      CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 32'd1);
    localparam logic [2:0]       RST_SEL  = 3'(DEFAULT_SEL);

    function automatic logic [31:0] rate_of(input logic [2:0] idx);
        case (idx)
            3'd0:    rate_of = 32'd1200;
            3'd1:    rate_of = 32'd2400;
            3'd2:    rate_of = 32'd4800;
            3'd3:    rate_of = 32'd9600;
            3'd4:    rate_of = 32'd19200;
            3'd5:    rate_of = 32'd38400;
            3'd6:    rate_of = 32'd57600;
            default: rate_of = 32'd115200;
        endcase
    endfunction

    // Rounded phase step per clock; only ever evaluated on constants.
    function automatic logic [ACC_W-1:0] inc_of(input logic [2:0] idx);
        logic [127:0] num;
        num    = (128'(rate_of(idx)) * 128'(OVERSAMPLE)) << ACC_W;
        num    = num + 128'(CLK_HZ / 32'd2);
        inc_of = ACC_W'(num / 128'(CLK_HZ));
    endfunction

    localparam logic [ACC_W-1:0] INC0 = inc_of(3'd0);
    localparam logic [ACC_W-1:0] INC1 = inc_of(3'd1);
    localparam logic [ACC_W-1:0] INC2 = inc_of(3'd2);
    localparam logic [ACC_W-1:0] INC3 = inc_of(3'd3);
    localparam logic [ACC_W-1:0] INC4 = inc_of(3'd4);
    localparam logic [ACC_W-1:0] INC5 = inc_of(3'd5);
    localparam logic [ACC_W-1:0] INC6 = inc_of(3'd6);
    localparam logic [ACC_W-1:0] INC7 = inc_of(3'd7);

    if (32'd115200 * OVERSAMPLE >= CLK_HZ / 32'd2) begin : g_rate_too_high
        $error("baud_gen_frac: 115200 * OVERSAMPLE must stay below CLK_HZ/2");
    end
    if (OVERSAMPLE < 32'd4 || OVERSAMPLE > 32'd16) begin : g_os_range
        $error("baud_gen_frac: OVERSAMPLE must be within 4..16");
    end

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
    logic             os_tick_q, os_tick_d;
    logic             bit_tick_q, bit_tick_d;
    logic [2:0]       cur_sel_q, cur_sel_d;
    logic [2:0]       pend_sel_q, pend_sel_d;
    logic             sel_pend_q, sel_pend_d;
    logic [ACC_W-1:0] inc_s;
    logic [ACC_W:0]   sum_s;
    logic             apply_s;
    logic [2:0]       apply_sel_s;

    // Phase increment for the rate currently in effect.
    always_comb begin
        case (cur_sel_q)
            3'd0:    inc_s = INC0;
            3'd1:    inc_s = INC1;
            3'd2:    inc_s = INC2;
            3'd3:    inc_s = INC3;
            3'd4:    inc_s = INC4;
            3'd5:    inc_s = INC5;
            3'd6:    inc_s = INC6;
            default: inc_s = INC7;
        endcase
    end

    // Next state: accumulate phase, derive ticks, and handle rate changes.
    always_comb begin
        sum_s       = {1'b0, acc_q} + {1'b0, inc_s};
        apply_s     = bit_tick_q && (sel_load || sel_pend_q);
        apply_sel_s = sel_load ? baud_sel : pend_sel_q;
        acc_d       = acc_q;
        os_cnt_d    = os_cnt_q;
        os_tick_d   = 1'b0;
        bit_tick_d  = 1'b0;
        cur_sel_d   = cur_sel_q;
        pend_sel_d  = pend_sel_q;
        sel_pend_d  = sel_pend_q;
        if (!en) begin
            acc_d      = '0;
            os_cnt_d   = '0;
            sel_pend_d = 1'b0;
            if (sel_load || sel_pend_q) begin
                cur_sel_d  = apply_sel_s;
                pend_sel_d = apply_sel_s;
            end else begin
                cur_sel_d  = cur_sel_q;
            end
        end else if (apply_s) begin
            // Bit boundary: switch rate and restart phase so no bit is truncated.
            acc_d      = '0;
            os_cnt_d   = '0;
            cur_sel_d  = apply_sel_s;
            pend_sel_d = apply_sel_s;
            sel_pend_d = 1'b0;
        end else begin
            acc_d      = sum_s[ACC_W-1:0];
            os_tick_d  = sum_s[ACC_W];
            bit_tick_d = sum_s[ACC_W] && (os_cnt_q == CNT_LAST);
            if (sum_s[ACC_W]) begin
                os_cnt_d = (os_cnt_q == CNT_LAST) ? '0 : os_cnt_q + CNT_W'(1);
            end else begin
                os_cnt_d = os_cnt_q;
            end
            if (sel_load) begin
                pend_sel_d = baud_sel;
                sel_pend_d = 1'b1;
            end else begin
                sel_pend_d = sel_pend_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= '0;
            os_cnt_q   <= '0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
            cur_sel_q  <= RST_SEL;
            pend_sel_q <= RST_SEL;
            sel_pend_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            os_cnt_q   <= os_cnt_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
            cur_sel_q  <= cur_sel_d;
            pend_sel_q <= pend_sel_d;
            sel_pend_q <= sel_pend_d;
        end
    end

    assign os_tick  = os_tick_q;
    assign bit_tick = bit_tick_q;
    assign cur_sel  = cur_sel_q;
    assign sel_pend = sel_pend_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: scoreboard of predicted tick cycles
// plus directed rate-change, enable and reset scenarios.
module tb_baud_gen_frac;

    localparam int unsigned CLK_HZ = 20_000_000;
    localparam int unsigned OS     = 8;
    localparam int unsigned ACC_W  = 32;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       en       = 1'b0;
    logic [2:0] baud_sel = 3'd0;
    logic       sel_load = 1'b0;
    logic       os_tick;
    logic       bit_tick;
    logic [2:0] cur_sel;
    logic       sel_pend;

    always #5 clk = ~clk;

    baud_gen_frac #(
        .CLK_HZ(CLK_HZ), .OVERSAMPLE(OS), .ACC_W(ACC_W), .DEFAULT_SEL(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .baud_sel(baud_sel),
        .sel_load(sel_load), .os_tick(os_tick), .bit_tick(bit_tick),
        .cur_sel(cur_sel), .sel_pend(sel_pend)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    endtask

    task automatic fail(input string name, input longint act);
        n_checks++;
        $display("FAIL %s: value %0d", name, act);
    endtask

    // ---------------- reference model ----------------
    function automatic longint unsigned rate_hz(input int idx);
        longint unsigned tbl [8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};
        return tbl[idx];
    endfunction

    function automatic longint unsigned inc_of(input int idx);
        return (rate_hz(idx) * OS * (64'd1 << ACC_W) + CLK_HZ / 2) / CLK_HZ;
    endfunction

    // An os tick occurs when the ideal phase n*INC passes a whole turn.
    function automatic bit crosses(input longint unsigned n, input longint unsigned inc);
        return ((n * inc) >> ACC_W) != (((n - 1) * inc) >> ACC_W);
    endfunction

    typedef struct { longint cyc; bit is_bit; } ev_t;
    ev_t             exp_q [$];
    longint          cyc = 0;
    int              m_sel = 3, m_pend_sel = 3;
    bit              m_pend = 1'b0, m_bit = 1'b0;
    longint unsigned m_n = 0;
    int              m_ticks = 0;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_sel = 3; m_pend_sel = 3; m_pend = 1'b0; m_bit = 1'b0;
                m_n = 0; m_ticks = 0; exp_q.delete();
            end else begin
                cyc++;
                if (!en) begin
                    if (sel_load) m_sel = int'(baud_sel);
                    else if (m_pend) m_sel = m_pend_sel;
                    m_pend = 1'b0; m_n = 0; m_ticks = 0; m_bit = 1'b0;
                end else if (m_bit && (sel_load || m_pend)) begin
                    m_sel  = sel_load ? int'(baud_sel) : m_pend_sel;
                    m_pend = 1'b0; m_n = 0; m_ticks = 0; m_bit = 1'b0;
                end else begin
                    m_n++;
                    if (crosses(m_n, inc_of(m_sel))) begin
                        m_ticks++;
                        m_bit = (m_ticks % OS) == 0;
                        exp_q.push_back('{cyc, m_bit});
                    end else begin
                        m_bit = 1'b0;
                    end
                    if (sel_load) begin
                        m_pend_sel = int'(baud_sel);
                        m_pend     = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic [3:0] prev_dut = 4'b0110;
    logic [3:0] prev_mod = 4'b0110;

    initial begin
        ev_t        e;
        logic [3:0] now_dut, now_mod;
        forever begin
            @(negedge clk);
            now_dut = {cur_sel, sel_pend};
            now_mod = {3'(m_sel), m_pend};
            if (now_dut != prev_dut || now_mod != prev_mod)
                check("status {cur_sel,sel_pend}", now_dut, now_mod);
            prev_dut = now_dut;
            prev_mod = now_mod;
            if (os_tick) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected os_tick at cycle", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("os_tick cycle", cyc, e.cyc);
                    check("bit_tick flag", bit_tick, e.is_bit);
                end
            end else begin
                if (bit_tick) fail("bit_tick without os_tick at cycle", cyc);
                while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    fail("missing os_tick expected at cycle", exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    longint scyc = 0;

    task automatic step();
        @(posedge clk);
        #2;
        scyc++;
    endtask

    task automatic wait_os(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (os_tick) begin ok = 1'b1; break; end
        end
        if (!ok) fail("timeout waiting for os_tick", budget);
    endtask

    task automatic wait_bit(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (bit_tick) begin ok = 1'b1; break; end
        end
        if (!ok) fail("timeout waiting for bit_tick", budget);
    endtask

    task automatic latency(output int lat);
        lat = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            lat++;
            if (os_tick) break;
        end
    endtask

    task automatic pulse_sel(input logic [2:0] s);
        baud_sel = s; sel_load = 1'b1;
        step();
        sel_load = 1'b0;
    endtask

    longint t_first, t_prev, t0, d, lo;
    int     bad, bits, cnt, lat1, lat2, k4, quiet;

    initial begin
        // T1: reset held with en high
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("T1 outputs in reset", {os_tick, bit_tick, cur_sel, sel_pend}, 6'b00_011_0);
        end
        reset_n = 1'b1;
        step();
        check("T1 outputs after release", {os_tick, bit_tick, cur_sel, sel_pend}, 6'b00_011_0);

        // T2: 9600 spacing, 96-tick span, bit count
        lo = CLK_HZ / (9600 * OS);
        wait_os(400);
        t_first = scyc; t_prev = scyc; bad = 0; bits = 0;
        for (int k = 0; k < 96; k++) begin
            wait_os(400);
            d = scyc - t_prev; t_prev = scyc;
            if (d < lo || d > lo + 1) bad++;
            if (bit_tick) bits++;
        end
        check("T2 spacings outside floor/ceil", bad, 0);
        check_range("T2 96-tick span", t_prev - t_first,
                    96 * CLK_HZ / (9600 * OS) - 1, 96 * CLK_HZ / (9600 * OS) + 1);
        check("T2 bit_ticks in 96 os_ticks", bits, 12);

        // T3: select 115200 while idle, then run
        en = 1'b0;
        pulse_sel(3'd7);
        check("T3 cur_sel after idle load", cur_sel, 7);
        check("T3 sel_pend after idle load", sel_pend, 0);
        en = 1'b1;
        lo = CLK_HZ / (115200 * OS);
        bad = 0; cnt = 0;
        for (int k = 0; k < 24; k++) begin
            wait_os(100);
            cnt++;
            if (k > 0) begin
                d = scyc - t_prev;
                if (d < lo || d > lo + 1) bad++;
            end
            t_prev = scyc;
            if (bit_tick) begin
                check("T3 os_ticks per bit_tick", cnt, OS);
                cnt = 0;
            end
        end
        check("T3 spacings outside floor/ceil", bad, 0);

        // T4: deferred change 9600 -> 1200
        en = 1'b0;
        pulse_sel(3'd3);
        en = 1'b1;
        repeat (1000) step();
        pulse_sel(3'd0);
        check("T4 sel_pend after mid-bit load", sel_pend, 1);
        check("T4 cur_sel held mid-bit", cur_sel, 3);
        wait_bit(3000);
        t0 = scyc;
        step();
        check("T4 cur_sel after boundary", cur_sel, 0);
        check("T4 sel_pend after boundary", sel_pend, 0);
        wait_bit(20000);
        check_range("T4 first 1200 bit length", scyc - t0,
                    CLK_HZ / 1200 - 8, CLK_HZ / 1200 + 9);

        // T5: last write wins, then bypass on a bit_tick cycle
        en = 1'b0;
        pulse_sel(3'd3);
        en = 1'b1;
        repeat (500) step();
        pulse_sel(3'd5);
        repeat (100) step();
        pulse_sel(3'd6);
        check("T5 sel_pend after two loads", sel_pend, 1);
        check("T5 cur_sel before boundary", cur_sel, 3);
        wait_bit(3000);
        step();
        check("T5 single apply cur_sel", cur_sel, 6);
        check("T5 sel_pend cleared", sel_pend, 0);
        wait_bit(1000);
        check("T5 sel_pend in bit_tick cycle", sel_pend, 0);
        pulse_sel(3'd2);
        check("T5 bypass cur_sel", cur_sel, 2);
        check("T5 bypass sel_pend", sel_pend, 0);

        // T6: enable drop with pending change, deterministic restart latency
        repeat (200) step();
        pulse_sel(3'd4);
        check("T6 sel_pend before en drop", sel_pend, 1);
        en = 1'b0;
        quiet = 0;
        step();
        check("T6 cur_sel on first idle edge", cur_sel, 4);
        check("T6 sel_pend on first idle edge", sel_pend, 0);
        quiet += int'(os_tick) + int'(bit_tick);
        repeat (4) begin step(); quiet += int'(os_tick) + int'(bit_tick); end
        check("T6 ticks while idle", quiet, 0);
        k4 = int'(((64'd1 << ACC_W) + inc_of(4) - 1) / inc_of(4));
        en = 1'b1;
        latency(lat1);
        check("T6 first os_tick latency", lat1, k4);
        repeat (50) step();
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        latency(lat2);
        check("T6 repeat latency", lat2, k4);

        // Reset pulse mid-bit discards a pending change
        repeat (100) step();
        pulse_sel(3'd1);
        check("T6 sel_pend before reset", sel_pend, 1);
        reset_n = 1'b0;
        #1;
        check("T6 outputs at reset assert", {os_tick, bit_tick, cur_sel, sel_pend}, 6'b00_011_0);
        step();
        check("T6 outputs during reset", {os_tick, bit_tick, cur_sel, sel_pend}, 6'b00_011_0);
        reset_n = 1'b1;
        step();
        check("T6 outputs after release", {os_tick, bit_tick, cur_sel, sel_pend}, 6'b00_011_0);
        repeat (3000) step();
        en = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
